sec_and_pipe: RTL and testbench
===============================

Name: sec_and_pipe

Overview:
- Parametrised N-share Boolean-masked AND gadget with valid/ready flow control, a randomness-valid handshake, per-transaction mode (AND/OR/XOR), 1 or 2 cycles latency, and a saturating randomness-starvation counter.
- Sits in the B2A conversion datapath: it takes shared operands from the upstream share generator and feeds the adder/refresh stages.
- Supports any N_SHARES >= 2.

Parameters:
- K_WIDTH, 32, bit width of each share.
- N_SHARES, 3, number of shares; must be >= 2.
- OUT_REG, 1, 0 = latency 1 (z combinational from stage-1 regs), 1 = latency 2 (z registered).
- RANDNUM, N_SHARES*(N_SHARES-1), random words consumed per AND/OR operation (derived; not overridden).
- CNT_W, 16, width of starvation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- dvld  in  1  input operands valid.
- drdy  out  1  block can accept operands this cycle.
- mode  in  2  00 AND, 01 OR, 10 XOR, 11 reserved (treated as AND).
- rnd  in  K_WIDTH*RANDNUM  fresh randomness; words 0..P-1 = r1, P..2P-1 = r2, P = N(N-1)/2.
- rnd_vld  in  1  rnd holds fresh unused words.
- rnd_take  out  1  rnd consumed this cycle (rnd source must advance).
- x  in  K_WIDTH*N_SHARES  share i at bits [i*K +: K].
- y  in  K_WIDTH*N_SHARES  same packing as x.
- z  out  K_WIDTH*N_SHARES  result shares, same packing.
- ovld  out  1  z valid.
- ordy  in  1  downstream accepts z.
- stall_cnt  out  CNT_W  saturating count of cycles stalled for lack of rnd.

Behaviour:
- Reset (async, rst_n=0): all pipeline regs, z, ovld, stall_cnt = 0; drdy=0, rnd_take=0 while in reset. In-flight tokens are discarded; no partial output after release.
- Pair index for i<j: p(i,j) = N*i - i(i+1)/2 + (j-i-1); r1[p], r2[p] are shared by the ordered pairs (i,j) and (j,i).
- Stage 1 (registered on accept), for each i and each j != i:
  - u1[i][j] = y_j ^ r1[p]
  - u2[i][j] = (~x_i & r1[p]) ^ r2[p]
  - also registers x_i, x_i & y_i, and the mode.
- Combine: c[i][j] = (x_i & u1[i][j]) ^ u2[i][j]; z_i = (x_i & y_i) ^ XOR over j != i of c[i][j]. Unmasked result is XOR_i z_i = (XOR x) & (XOR y).
- OR mode: share 0 of x and share 0 of y are inverted before stage 1, and share 0 of z is inverted at output (De Morgan). No other share is touched.
- XOR mode: z_i = x_i ^ y_i. No randomness needed; rnd_vld is ignored; rnd_take = 0.
- Accept condition: acc = ena & dvld & drdy.
  - drdy = ena & (stage-1 empty or stage-1 advancing this cycle) & (rnd_vld or mode==XOR).
  - rnd_take = acc & (mode != XOR). A rnd word is never used twice.
- Latency from acc to ovld:
  - OUT_REG=0: 1 cycle.
  - OUT_REG=1: 2 cycles.
  - Full throughput of 1 op/cycle when ordy=1.
- Backpressure: ovld & !ordy holds z and ovld stable. Upstream stages fill, then drdy drops. No token is lost or duplicated. Output transfer = ovld & ordy & ena.
- ena=0: no register updates, drdy=0, rnd_take=0; z and ovld hold their values.
- stall_cnt increments when ena & dvld & stage can advance & !rnd_vld & mode != XOR. It saturates at 2^CNT_W-1 and clears only on reset.
- Simultaneous accept and output transfer in the same cycle: both happen; the pipeline stays full.
- Per-transaction mode is carried with its token; a mode change between tokens needs no bubble.
- Security:
  - Every share-crossing term passes through a register before the XOR tree.
  - The XOR tree for z_i is reduced in fixed order j = ascending, skipping i.
  - Share-separated logic is not merged (DONT_TOUCH on share wires).

Test Plan:
- N=3, K=8, OUT_REG=1, AND, x shares {0x3C,0x5A,0x00} (value 0x66), y shares {0xF0,0x0F,0x11} (value 0xEE), random rnd, ordy=1 -> ovld 2 cycles after accept; XOR of z shares = 0x66; rnd_take pulses once.
- Same operands, mode=OR -> XOR of z shares = 0xEE; mode=XOR -> XOR of z shares = 0x88 with rnd_vld=0 and rnd_take=0.
- rnd_vld=0 for 5 cycles with dvld=1, AND -> drdy=0 for 5 cycles, stall_cnt=5, then accept; result still correct.
- Back-to-back 16 random ops, ordy toggling 1010… -> all 16 results correct and in order; z stable while ovld & !ordy; no dropped or duplicated tokens.
- N=2 and N=5, 1000 random ops each, OUT_REG=0 -> latency 1 and the unmasked result equals the reference AND in every case.
- Assert rst_n=0 mid-stream with 2 tokens in flight -> ovld=0 and z=0 immediately; after release no stale ovld; the next op completes correctly.

Source files
------------

// File: rtl/sec_and_pipe.sv
// N-share Boolean-masked AND/OR/XOR gadget with valid/ready flow control, a
// randomness handshake and a saturating randomness-starvation counter.
module sec_and_pipe #(
  parameter int unsigned  K_WIDTH  = 32,
  parameter int unsigned  N_SHARES = 3,
  parameter int unsigned  OUT_REG  = 1,
  parameter int unsigned  CNT_W    = 16,
  localparam int unsigned RANDNUM  = N_SHARES * (N_SHARES - 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        dvld,
  output logic                        drdy,
  input  logic [1:0]                  mode,
  input  logic [K_WIDTH*RANDNUM-1:0]  rnd,
  input  logic                        rnd_vld,
  output logic                        rnd_take,
  input  logic [K_WIDTH*N_SHARES-1:0] x,
  input  logic [K_WIDTH*N_SHARES-1:0] y,
  output logic [K_WIDTH*N_SHARES-1:0] z,
  output logic                        ovld,
  input  logic                        ordy,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int unsigned PAIRS    = RANDNUM / 2;
  localparam int unsigned ZW       = K_WIDTH * N_SHARES;
  localparam logic [1:0]  MODE_OR  = 2'b01;
  localparam logic [1:0]  MODE_XOR = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [K_WIDTH-1:0] word_t;

  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    return N_SHARES * i - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Unordered pair (i,j) selects the same r1/r2 word for both (i,j) and (j,i).
  function automatic word_t r_word(input logic [K_WIDTH*RANDNUM-1:0] r,
                                   input int unsigned i, input int unsigned j,
                                   input int unsigned half);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return r[(half * PAIRS + pair_idx(lo, hi)) * K_WIDTH +: K_WIDTH];
  endfunction

  logic       s1_vld_q, s1_vld_d;
  logic [1:0] mode_q;
  logic       s1_adv, s1_free, mode_xor, acc;
  logic       stall_inc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [ZW-1:0]    z_c;

  word_t xin  [N_SHARES];
  word_t yin  [N_SHARES];
  word_t x_d  [N_SHARES];
  word_t xy_d [N_SHARES];
  word_t u1_d [N_SHARES][N_SHARES];
  word_t u2_d [N_SHARES][N_SHARES];
  word_t zs   [N_SHARES];

  (* dont_touch = "true" *) word_t x_q  [N_SHARES];
  (* dont_touch = "true" *) word_t xy_q [N_SHARES];
  (* dont_touch = "true" *) word_t u1_q [N_SHARES][N_SHARES];
  (* dont_touch = "true" *) word_t u2_q [N_SHARES][N_SHARES];

  assign mode_xor = (mode == MODE_XOR);
  assign s1_free  = !s1_vld_q || s1_adv;
  assign drdy     = rst_n & ena & s1_free & (rnd_vld | mode_xor);
  assign acc      = ena & dvld & drdy;
  assign rnd_take = acc & !mode_xor;
  assign s1_vld_d = acc | (s1_vld_q & !s1_adv);

  // OR is computed as AND on inverted share 0 (De Morgan).
  always_comb begin : share_in
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      xin[i] = x[i*K_WIDTH +: K_WIDTH];
      yin[i] = y[i*K_WIDTH +: K_WIDTH];
    end
    if (mode == MODE_OR) begin
      xin[0] = ~xin[0];
      yin[0] = ~yin[0];
    end
  end

  always_comb begin : stage1_next
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      x_d[i]  = xin[i];
      xy_d[i] = mode_xor ? (xin[i] ^ yin[i]) : (xin[i] & yin[i]);
      for (int unsigned j = 0; j < N_SHARES; j++) begin
        u1_d[i][j] = '0;
        u2_d[i][j] = '0;
        if (i != j && !mode_xor) begin
          u1_d[i][j] = yin[j] ^ r_word(rnd, i, j, 0);
          u2_d[i][j] = (~xin[i] & r_word(rnd, i, j, 0)) ^ r_word(rnd, i, j, 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stage1_regs
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      mode_q   <= '0;
      for (int unsigned i = 0; i < N_SHARES; i++) begin
        x_q[i]  <= '0;
        xy_q[i] <= '0;
        for (int unsigned j = 0; j < N_SHARES; j++) begin
          u1_q[i][j] <= '0;
          u2_q[i][j] <= '0;
        end
      end
    end else begin
      s1_vld_q <= s1_vld_d;
      if (acc) begin
        mode_q <= mode;
        for (int unsigned i = 0; i < N_SHARES; i++) begin
          x_q[i]  <= x_d[i];
          xy_q[i] <= xy_d[i];
          for (int unsigned j = 0; j < N_SHARES; j++) begin
            u1_q[i][j] <= u1_d[i][j];
            u2_q[i][j] <= u2_d[i][j];
          end
        end
      end
    end
  end

  // Per-share XOR tree, fixed ascending order over j != i.
  always_comb begin : combine
    z_c = '0;
    for (int unsigned i = 0; i < N_SHARES; i++) begin
      zs[i] = xy_q[i];
      if (mode_q != MODE_XOR) begin
        for (int unsigned j = 0; j < N_SHARES; j++) begin
          if (j != i) begin
            zs[i] = zs[i] ^ ((x_q[i] & u1_q[i][j]) ^ u2_q[i][j]);
          end
        end
      end
      if (i == 0 && mode_q == MODE_OR) begin
        zs[i] = ~zs[i];
      end
      z_c[i*K_WIDTH +: K_WIDTH] = zs[i];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          ovld_q, ovld_d;
      logic [ZW-1:0] z_q, z_d;

      assign s1_adv = ena & s1_vld_q & (!ovld_q | ordy);
      assign z_d    = s1_adv ? z_c : z_q;
      assign ovld_d = !ena ? ovld_q : (s1_vld_q | (ovld_q & !ordy));

      always_ff @(posedge clk or negedge rst_n) begin : out_regs
        if (!rst_n) begin
          ovld_q <= 1'b0;
          z_q    <= '0;
        end else begin
          ovld_q <= ovld_d;
          z_q    <= z_d;
        end
      end

      assign z    = z_q;
      assign ovld = ovld_q;
    end else begin : g_out_comb
      assign s1_adv = ena & s1_vld_q & ordy;
      assign z      = z_c;
      assign ovld   = s1_vld_q;
    end
  endgenerate

  assign stall_inc   = ena & dvld & s1_free & !rnd_vld & !mode_xor & (stall_cnt_q != CNT_MAX);
  assign stall_cnt_d = stall_inc ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin : stall_reg
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_sec_and_pipe.sv
// Directed bench for sec_and_pipe: N=3/OUT_REG=1 main instance plus
// N=2 and N=5 OUT_REG=0 instances for latency-1 random checks.
module tb_sec_and_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena;
  logic        dvld, drdy, rnd_vld, rnd_take, ovld, ordy;
  logic [1:0]  mode;
  logic [47:0] rnd;
  logic [23:0] x, y, z;
  logic [15:0] stall_cnt;

  logic        a_dvld, a_drdy, a_take, a_ovld;
  logic [1:0]  a_mode;
  logic [15:0] a_rnd, a_x, a_y, a_z;
  logic [15:0] a_stall;

  logic         b_dvld, b_drdy, b_take, b_ovld;
  logic [1:0]   b_mode;
  logic [159:0] b_rnd;
  logic [39:0]  b_x, b_y, b_z;
  logic [15:0]  b_stall;

  int n_tests = 0;
  int n_fail  = 0;

  sec_and_pipe #(.K_WIDTH(8), .N_SHARES(3), .OUT_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld), .drdy(drdy), .mode(mode),
    .rnd(rnd), .rnd_vld(rnd_vld), .rnd_take(rnd_take), .x(x), .y(y), .z(z),
    .ovld(ovld), .ordy(ordy), .stall_cnt(stall_cnt)
  );

  sec_and_pipe #(.K_WIDTH(8), .N_SHARES(2), .OUT_REG(0), .CNT_W(16)) dut_n2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(a_dvld), .drdy(a_drdy), .mode(a_mode),
    .rnd(a_rnd), .rnd_vld(1'b1), .rnd_take(a_take), .x(a_x), .y(a_y), .z(a_z),
    .ovld(a_ovld), .ordy(1'b1), .stall_cnt(a_stall)
  );

  sec_and_pipe #(.K_WIDTH(8), .N_SHARES(5), .OUT_REG(0), .CNT_W(16)) dut_n5 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(b_dvld), .drdy(b_drdy), .mode(b_mode),
    .rnd(b_rnd), .rnd_vld(1'b1), .rnd_take(b_take), .x(b_x), .y(b_y), .z(b_z),
    .ovld(b_ovld), .ordy(1'b1), .stall_cnt(b_stall)
  );

  function automatic logic [7:0] um3(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  function automatic logic [7:0] um2(input logic [15:0] v);
    return v[7:0] ^ v[15:8];
  endfunction

  function automatic logic [7:0] um5(input logic [39:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = r ^ v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] m);
    case (m)
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Presents one op on the main instance (caller aligned just after posedge),
  // returns drdy/rnd_take seen before the accept edge and the first valid z.
  task automatic send_op(input logic [23:0] xs, input logic [23:0] ys, input logic [1:0] md,
                         input logic rv, output logic dr, output logic tk,
                         output int lat, output int takes, output logic [23:0] zo);
    x = xs; y = ys; mode = md; rnd_vld = rv; dvld = 1'b1;
    rnd = 48'({$urandom(), $urandom()});
    @(negedge clk);
    dr = drdy; tk = rnd_take; takes = int'(rnd_take);
    @(posedge clk); #1;
    dvld = 1'b0; rnd_vld = 1'b0;
    lat = 0; zo = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      takes += int'(rnd_take);
      if (ovld) begin lat = c; zo = z; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; dvld = 1'b1; rnd_vld = 1'b1; mode = 2'b00; ordy = 1'b1;
    x = 24'h005A3C; y = 24'h110FF0; rnd = 48'h1234_5678_9ABC;
    repeat (2) @(negedge clk);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL reset_ovld: got %b want 0", ovld); end
    n_tests++; if (z !== 24'h0) begin n_fail++; $display("FAIL reset_z: got %h want 000000", z); end
    n_tests++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    n_tests++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL reset_drdy: got %b want 0", drdy); end
    n_tests++; if (rnd_take !== 1'b0) begin n_fail++; $display("FAIL reset_take: got %b want 0", rnd_take); end
    n_tests++; if ({a_ovld, b_ovld} !== 2'b00) begin n_fail++; $display("FAIL reset_sub_ovld: got %b want 00", {a_ovld, b_ovld}); end
    dvld = 1'b0; rnd_vld = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    send_op(24'h005A3C, 24'h110FF0, 2'b00, 1'b1, dr, tk, lat, takes, zo);
    n_tests++; if (dr !== 1'b1) begin n_fail++; $display("FAIL and_drdy: got %b want 1", dr); end
    n_tests++; if (tk !== 1'b1) begin n_fail++; $display("FAIL and_take: got %b want 1", tk); end
    n_tests++; if (takes != 1) begin n_fail++; $display("FAIL and_take_count: got %0d want 1", takes); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL and_latency: got %0d want 2", lat); end
    n_tests++; if (um3(zo) !== 8'h66) begin n_fail++; $display("FAIL and_value: got %h want 66", um3(zo)); end
  endtask

  task automatic test_or();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    send_op(24'h005A3C, 24'h110FF0, 2'b01, 1'b1, dr, tk, lat, takes, zo);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL or_latency: got %0d want 2", lat); end
    n_tests++; if (takes != 1) begin n_fail++; $display("FAIL or_take_count: got %0d want 1", takes); end
    n_tests++; if (um3(zo) !== 8'hEE) begin n_fail++; $display("FAIL or_value: got %h want ee", um3(zo)); end
  endtask

  task automatic test_xor();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    send_op(24'h005A3C, 24'h110FF0, 2'b10, 1'b0, dr, tk, lat, takes, zo);
    n_tests++; if (dr !== 1'b1) begin n_fail++; $display("FAIL xor_drdy: got %b want 1", dr); end
    n_tests++; if (takes != 0) begin n_fail++; $display("FAIL xor_take: got %0d want 0", takes); end
    n_tests++; if (um3(zo) !== 8'h88) begin n_fail++; $display("FAIL xor_value: got %h want 88", um3(zo)); end
    n_tests++; if (zo !== 24'h1155CC) begin n_fail++; $display("FAIL xor_shares: got %h want 1155cc", zo); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL xor_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_starve();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    x = 24'h005A3C; y = 24'h110FF0; mode = 2'b00; rnd_vld = 1'b0; dvld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL starve_drdy[%0d]: got %b want 0", c, drdy); end
      @(posedge clk); #1;
    end
    n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL starve_cnt: got %0d want 5", stall_cnt); end
    send_op(24'h005A3C, 24'h110FF0, 2'b00, 1'b1, dr, tk, lat, takes, zo);
    n_tests++; if (dr !== 1'b1) begin n_fail++; $display("FAIL starve_accept: got %b want 1", dr); end
    n_tests++; if (um3(zo) !== 8'h66) begin n_fail++; $display("FAIL starve_value: got %h want 66", um3(zo)); end
    n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL starve_cnt_hold: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_enable();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    ena = 1'b0; dvld = 1'b1; rnd_vld = 1'b1; mode = 2'b00; x = 24'h005A3C; y = 24'h110FF0;
    @(negedge clk);
    n_tests++; if ({drdy, rnd_take} !== 2'b00) begin n_fail++; $display("FAIL ena_low_hs: got %b want 00", {drdy, rnd_take}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL ena_low_noacc: got %b want 0", ovld); end
    @(posedge clk); #1;
    ena = 1'b1; ordy = 1'b0;
    send_op(24'h005A3C, 24'h110FF0, 2'b00, 1'b1, dr, tk, lat, takes, zo);
    ena = 1'b0; ordy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (ovld !== 1'b1 || z !== zo) begin n_fail++; $display("FAIL ena_hold: got ovld=%b z=%h want ovld=1 z=%h", ovld, z, zo); end
    ena = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL ena_release: got %b want 0", ovld); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [23:0] bx [16];
    logic [23:0] by [16];
    logic [1:0]  bm [16];
    logic [7:0]  bexp [16];
    logic [23:0] pz;
    logic        hold;
    int sent, recv, cyc;
    for (int k = 0; k < 16; k++) begin
      bx[k] = 24'($urandom()); by[k] = 24'($urandom()); bm[k] = 2'($urandom());
      bexp[k] = ref_op(um3(bx[k]), um3(by[k]), bm[k]);
    end
    sent = 0; recv = 0; cyc = 0; hold = 1'b0; pz = '0;
    while (recv < 16 && cyc < 200) begin
      ordy = (cyc % 2 == 0);
      if (sent < 16) begin
        dvld = 1'b1; rnd_vld = 1'b1; x = bx[sent]; y = by[sent]; mode = bm[sent];
        rnd = 48'({$urandom(), $urandom()});
      end else begin
        dvld = 1'b0; rnd_vld = 1'b0;
      end
      @(negedge clk);
      if (hold) begin
        n_tests++;
        if (ovld !== 1'b1 || z !== pz) begin n_fail++; $display("FAIL b2b_hold[%0d]: got ovld=%b z=%h want ovld=1 z=%h", cyc, ovld, z, pz); end
      end
      if (ovld && ordy) begin
        n_tests++;
        if (um3(z) !== bexp[recv]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", recv, um3(z), bexp[recv]); end
        recv++;
      end
      hold = ovld & !ordy; pz = z;
      if (dvld && drdy) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    dvld = 1'b0; rnd_vld = 1'b0; ordy = 1'b1;
    n_tests++; if (recv != 16 || sent != 16) begin n_fail++; $display("FAIL b2b_count: got sent=%0d recv=%0d want 16/16", sent, recv); end
    @(negedge clk);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", ovld); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_lat1();
    logic       pv;
    logic [7:0] pe2, pe5;
    pv = 1'b0; pe2 = '0; pe5 = '0;
    for (int k = 0; k < 1000; k++) begin
      a_x = 16'($urandom()); a_y = 16'($urandom()); a_mode = 2'($urandom()); a_rnd = 16'($urandom());
      b_x = 40'({$urandom(), $urandom()}); b_y = 40'({$urandom(), $urandom()}); b_mode = 2'($urandom());
      b_rnd = 160'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      a_dvld = 1'b1; b_dvld = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({a_drdy, b_drdy} !== 2'b11 || a_take !== (a_mode != 2'b10) || b_take !== (b_mode != 2'b10)) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: got drdy=%b take=%b%b want 11 %b%b", k, {a_drdy, b_drdy}, a_take, b_take, a_mode != 2'b10, b_mode != 2'b10);
      end
      n_tests++;
      if (a_ovld !== pv || (pv && um2(a_z) !== pe2)) begin n_fail++; $display("FAIL rnd_n2[%0d]: got ovld=%b val=%h want ovld=%b val=%h", k, a_ovld, um2(a_z), pv, pe2); end
      n_tests++;
      if (b_ovld !== pv || (pv && um5(b_z) !== pe5)) begin n_fail++; $display("FAIL rnd_n5[%0d]: got ovld=%b val=%h want ovld=%b val=%h", k, b_ovld, um5(b_z), pv, pe5); end
      pv = 1'b1;
      pe2 = ref_op(um2(a_x), um2(a_y), a_mode);
      pe5 = ref_op(um5(b_x), um5(b_y), b_mode);
      @(posedge clk); #1;
    end
    a_dvld = 1'b0; b_dvld = 1'b0;
    @(negedge clk);
    n_tests++; if (a_ovld !== 1'b1 || um2(a_z) !== pe2) begin n_fail++; $display("FAIL rnd_n2_last: got %h want %h", um2(a_z), pe2); end
    n_tests++; if (b_ovld !== 1'b1 || um5(b_z) !== pe5) begin n_fail++; $display("FAIL rnd_n5_last: got %h want %h", um5(b_z), pe5); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if ({a_ovld, b_ovld} !== 2'b00) begin n_fail++; $display("FAIL rnd_drain: got %b want 00", {a_ovld, b_ovld}); end
    n_tests++; if ({a_stall, b_stall} !== 32'h0) begin n_fail++; $display("FAIL rnd_stall: got %h want 0", {a_stall, b_stall}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic dr, tk; int lat, takes; logic [23:0] zo;
    ordy = 1'b0; dvld = 1'b1; rnd_vld = 1'b1; mode = 2'b00;
    x = 24'h123456; y = 24'hABCDEF; rnd = 48'({$urandom(), $urandom()});
    @(posedge clk); #1;
    x = 24'h654321; rnd = 48'({$urandom(), $urandom()});
    @(posedge clk); #1;
    dvld = 1'b0; rnd_vld = 1'b0;
    n_tests++; if (ovld !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b want 1", ovld); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ovld !== 1'b0 || z !== 24'h0) begin n_fail++; $display("FAIL mid_reset: got ovld=%b z=%h want 0 000000", ovld, z); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", c, ovld); end
    end
    @(posedge clk); #1;
    ordy = 1'b1;
    send_op(24'h005A3C, 24'h110FF0, 2'b00, 1'b1, dr, tk, lat, takes, zo);
    n_tests++; if (lat != 2 || um3(zo) !== 8'h66) begin n_fail++; $display("FAIL mid_next: got lat=%0d val=%h want 2 66", lat, um3(zo)); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_stall: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_dvld = 1'b0; a_mode = '0; a_rnd = '0; a_x = '0; a_y = '0;
    b_dvld = 1'b0; b_mode = '0; b_rnd = '0; b_x = '0; b_y = '0;
    test_reset();
    test_and();
    test_or();
    test_xor();
    test_starve();
    test_enable();
    test_back_to_back();
    test_random_lat1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
